bcd_seg_scan: RTL and testbench



---
 rtl/bcd_disp_pkg.sv | 38 +++
 rtl/seg7_decode.sv | 28 ++
 rtl/bcd_seg_scan.sv | 156 +++++++++++++++
 tb/tb_bcd_seg_scan.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit BCD scan display.
// Scan states, active-low segment/anode codes and small state helpers.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ST_DIG0 = 2'b00,
        ST_GAP0 = 2'b01,
        ST_DIG1 = 2'b10,
        ST_GAP1 = 2'b11
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_ONE   = 7'h79;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    function automatic scan_state_t next_scan_state(input scan_state_t s);
        scan_state_t n;
        n = ST_DIG0;
        case (s)
            ST_DIG0: n = ST_GAP0;
            ST_GAP0: n = ST_DIG1;
            ST_DIG1: n = ST_GAP1;
            ST_GAP1: n = ST_DIG0;
            default: n = ST_GAP1;
        endcase
        return n;
    endfunction

    function automatic logic is_digit_state(input scan_state_t s);
        return (s == ST_DIG0) || (s == ST_DIG1);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment code (gfedcba).
// Codes 10-15 are not valid BCD and display 'E'.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        seg = SEG_E;
        case (digit)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit common-anode scan driver with anti-ghosting gaps and frame-start commit.
// Optional blink gating is built when BCD_SEG_BLINK_EN is defined (adds BLINK port, BLINK_SH).
module bcd_seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int DIG_CYC = 50000,
    parameter int GAP_CYC = 500,
    parameter bit LZB     = 1'b1
`ifdef BCD_SEG_BLINK_EN
    ,
    parameter int BLINK_SH = 5
`endif
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] BCD,
    input  logic       LOAD,
`ifdef BCD_SEG_BLINK_EN
    input  logic       BLINK,
`endif
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       PENDING
);

    localparam int CNT_MAX = (DIG_CYC > GAP_CYC) ? DIG_CYC : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DIG_LAST = CW'(DIG_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

    if (DIG_CYC < 1) begin : g_bad_dig
        $error("DIG_CYC must be at least 1");
    end
    if (GAP_CYC < 1) begin : g_bad_gap
        $error("GAP_CYC must be at least 1");
    end

    scan_state_t   state_q;
    scan_state_t   state_d;
    logic [CW-1:0] cnt_q;
    logic          dwell_done;
    logic          commit;

    logic [4:0]    shadow_q;
    logic [4:0]    disp_q;
    logic          pending_q;

    logic [6:0]    units_seg;
    logic [6:0]    tens_seg;
    logic          blank_force;

    // ---------------- scan sequencer ----------------
    always_comb begin
        state_d    = state_q;
        dwell_done = 1'b0;
        if (is_digit_state(state_q)) begin
            dwell_done = (cnt_q == DIG_LAST);
        end else begin
            dwell_done = (cnt_q == GAP_LAST);
        end
        if (dwell_done) begin
            state_d = next_scan_state(state_q);
        end
    end

    // Frame start is the GAP1 -> DIG0 edge; buffered values land only here.
    assign commit = (state_q == ST_GAP1) && dwell_done;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_GAP1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (dwell_done) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // ---------------- shadow / display buffers ----------------
    // A LOAD on the commit edge refills the shadow after the old value moved to disp.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            if (commit && pending_q) begin
                disp_q <= shadow_q;
            end
            if (LOAD) begin
                shadow_q  <= BCD;
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign PENDING = pending_q;

`ifdef BCD_SEG_BLINK_EN
    logic [BLINK_SH:0] frame_cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt_q <= '0;
        end else if (commit) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign blank_force = BLINK && frame_cnt_q[BLINK_SH];
`else
    assign blank_force = 1'b0;
`endif

    // ---------------- digit decode and output mux ----------------
    seg7_decode u_units (
        .digit (disp_q[3:0]),
        .seg   (units_seg)
    );

    always_comb begin
        tens_seg = SEG_ONE;
        if (!disp_q[4]) begin
            tens_seg = LZB ? SEG_BLANK : SEG_ZERO;
        end
    end

    always_comb begin
        AN  = AN_OFF;
        SEG = SEG_BLANK;
        if (!blank_force) begin
            case (state_q)
                ST_DIG0: begin
                    AN  = AN_UNITS;
                    SEG = units_seg;
                end
                ST_DIG1: begin
                    AN  = AN_TENS;
                    SEG = tens_seg;
                end
                default: begin
                    AN  = AN_OFF;
                    SEG = SEG_BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: a frame-arithmetic model predicts every cycle's outputs
// for an LZB=1 and an LZB=0 instance driven by the same stimulus.
module tb_bcd_seg_scan;

    localparam int DIG = 8;
    localparam int GAP = 2;
    localparam int F   = 2 * (DIG + GAP);

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       load  = 1'b0;
    logic [4:0] bcd   = 5'd0;

    logic [6:0] seg1, seg0;
    logic [1:0] an1, an0;
    logic       pend1, pend0;

`ifdef BCD_SEG_BLINK_EN
    localparam int BSH = 1;
    logic blink = 1'b1;
`endif

    always #5 clk = ~clk;

    bcd_seg_scan #(
        .DIG_CYC (DIG),
        .GAP_CYC (GAP),
        .LZB     (1'b1)
`ifdef BCD_SEG_BLINK_EN
        , .BLINK_SH (BSH)
`endif
    ) dut_lzb1 (
        .CLK     (clk),
        .RST_N   (rst_n),
        .BCD     (bcd),
        .LOAD    (load),
        .SEG     (seg1),
        .AN      (an1),
        .PENDING (pend1)
`ifdef BCD_SEG_BLINK_EN
        , .BLINK (blink)
`endif
    );

    bcd_seg_scan #(
        .DIG_CYC (DIG),
        .GAP_CYC (GAP),
        .LZB     (1'b0)
`ifdef BCD_SEG_BLINK_EN
        , .BLINK_SH (BSH)
`endif
    ) dut_lzb0 (
        .CLK     (clk),
        .RST_N   (rst_n),
        .BCD     (bcd),
        .LOAD    (load),
        .SEG     (seg0),
        .AN      (an0),
        .PENDING (pend0)
`ifdef BCD_SEG_BLINK_EN
        , .BLINK (blink)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg1;
        logic [6:0] seg0;
        logic       pend;
    } exp_t;

    exp_t q[$];

    logic [6:0] units_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    int         k;          // clock edges since reset release
    logic [4:0] m_shadow;
    logic [4:0] m_disp;
    logic       m_pend;
    logic [7:0] m_frame;    // frame starts since reset

    function automatic exp_t expect_now();
        exp_t e;
        int   p;
        e.an   = 2'b11;
        e.seg1 = 7'h7F;
        e.seg0 = 7'h7F;
        e.pend = m_pend;
        if (k >= GAP) begin
            p = (k - GAP) % F;
            if (p < DIG) begin
                e.an   = 2'b10;
                e.seg1 = units_tab[m_disp[3:0]];
                e.seg0 = units_tab[m_disp[3:0]];
            end else if (p >= DIG + GAP && p < 2 * DIG + GAP) begin
                e.an   = 2'b01;
                e.seg1 = m_disp[4] ? 7'h79 : 7'h7F;
                e.seg0 = m_disp[4] ? 7'h79 : 7'h40;
            end
        end
`ifdef BCD_SEG_BLINK_EN
        if (blink && m_frame[BSH]) begin
            e.an   = 2'b11;
            e.seg1 = 7'h7F;
            e.seg0 = 7'h7F;
        end
`endif
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        = 0;
            m_shadow = '0;
            m_disp   = '0;
            m_pend   = 1'b0;
            m_frame  = '0;
            q.delete();
            q.push_back(expect_now());
        end else begin
            k++;
            if (k >= GAP && (k - GAP) % F == 0) begin
                if (m_pend) begin
                    m_disp = m_shadow;
                    m_pend = 1'b0;
                end
                m_frame++;
            end
            if (load) begin
                m_shadow = bcd;
                m_pend   = 1'b1;
            end
            q.push_back(expect_now());
        end
    end

    // ---------------- monitor ----------------
    int idle = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e    = q.pop_front();
            idle = 0;
            check("lzb1_an_seg_pend", {22'd0, an1, seg1, pend1}, {22'd0, e.an, e.seg1, e.pend});
            check("lzb0_an_seg_pend", {22'd0, an0, seg0, pend0}, {22'd0, e.an, e.seg0, e.pend});
        end else begin
            idle++;
            if (idle > 20) begin
                check("scoreboard_idle", idle, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at a falling edge whose following rising edge has frame phase 'target'.
    task automatic goto_edge(input int target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < F + 4; i++) begin
            @(negedge clk);
            if (k + 1 >= GAP && (k + 1 - GAP) % F == target) begin
                found = 1'b1;
                break;
            end
        end
        check("goto_edge_reached", {31'd0, found}, 32'd1);
    endtask

    task automatic do_load(input logic [4:0] v);
        bcd  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bcd  = 5'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        step(3);
        check("rst_an", {30'd0, an1}, 32'h3);
        check("rst_seg", {25'd0, seg1}, 32'h7F);
        check("rst_pending", {31'd0, pend1}, 32'd0);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_edge1_an", {30'd0, an1}, 32'h3);
        @(posedge clk);
        #1;
        check("post_rst_edge2_an", {30'd0, an1}, 32'h2);
        check("post_rst_edge2_seg", {25'd0, seg1}, 32'h40);

        // 17 loaded while the tens digit is lit
        goto_edge(DIG + GAP + 2);
        do_load(5'd17);
        check("pending_after_load", {31'd0, pend1}, 32'd1);
        step(2 * F);

        // leading-zero blanking on both instances
        goto_edge(DIG + GAP + 1);
        do_load(5'd3);
        step(2 * F);

        // illegal units code shows 'E'
        goto_edge(3);
        do_load(5'd12);
        step(2 * F);

        // last LOAD in a frame wins
        goto_edge(1);
        do_load(5'd9);
        goto_edge(DIG + GAP);
        do_load(5'd4);
        step(2 * F);

        // LOAD exactly on the commit edge
        goto_edge(5);
        do_load(5'd2);
        goto_edge(0);
        do_load(5'd6);
        check("pending_after_commit_collision", {31'd0, pend1}, 32'd1);
        step(2 * F);

        // asynchronous reset in the middle of DIG1 with a pending value
        goto_edge(DIG + GAP + 1);
        do_load(5'd5);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", {30'd0, an1}, 32'h3);
        check("async_rst_seg", {25'd0, seg1}, 32'h7F);
        check("async_rst_pending", {31'd0, pend1}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2 * F);

        // random LOAD traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                bcd  = 5'($urandom);
                load = 1'b1;
            end else begin
                load = 1'b0;
                bcd  = 5'($urandom);
            end
        end
        load = 1'b0;
        step(2 * F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
